// File: rtl/playback_sequencer.sv
// Transport controller: play/pause, song index and per-frame gain ramps on the PCM stream.
// Build option AUTO_ADVANCE_EN: end of song moves on to the next song instead of re-arming the current one.
module playback_sequencer #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_BITS = 2,
  parameter int GAIN_BITS = 5,
  parameter int FADE_STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_pulse,
  input  logic                 next_pulse,
  input  logic                 song_done,
  input  logic                 new_frame,
  input  logic [15:0]          sample_in,
  output logic [15:0]          sample_out,
  output logic                 player_enable,
  output logic                 player_restart,
  output logic [SONG_BITS-1:0] song_led,
  output logic                 play_led,
  output logic                 busy
);

  localparam int GW = GAIN_BITS + 1;
  localparam int PW = 16 + GAIN_BITS + 2;
  localparam logic [GW-1:0]        GAIN_MAX  = GW'(1 << GAIN_BITS);
  localparam logic [GW-1:0]        STEP      = GW'(FADE_STEP);
  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);

  typedef enum logic [2:0] {
    S_PAUSED   = 3'd0,
    S_FADE_IN  = 3'd1,
    S_PLAYING  = 3'd2,
    S_FADE_OUT = 3'd3,
    S_SWITCH   = 3'd4
  } state_e;

  // T_REARM: pause after the fade and reload the current song from its start.
  typedef enum logic [1:0] {
    T_PAUSE = 2'd0,
    T_NEXT  = 2'd1,
    T_REARM = 2'd2
  } target_e;

  state_e               state_q, state_d;
  target_e              target_q, target_d;
  logic [SONG_BITS-1:0] song_idx_q, song_idx_d;
  logic [GW-1:0]        gain_q, gain_d;
  logic [15:0]          sample_out_q, sample_out_d;
  logic                 player_enable_q, player_enable_d;
  logic                 player_restart_q, player_restart_d;
  logic                 play_led_q, play_led_d;
  logic                 busy_q, busy_d;

  logic [GW-1:0]        gain_up_s, gain_dn_s, gain_fo_s;
  logic [SONG_BITS-1:0] song_inc_s;
  logic signed [PW-1:0] samp_ext_s, gain_ext_s;

  // Next-state, next-gain and registered-output computation.
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    song_idx_d       = song_idx_q;
    gain_d           = gain_q;
    play_led_d       = play_led_q;
    player_restart_d = 1'b0;

    gain_up_s  = (gain_q >= (GAIN_MAX - STEP)) ? GAIN_MAX : (gain_q + STEP);
    gain_dn_s  = (gain_q <= STEP) ? {GW{1'b0}} : (gain_q - STEP);
    gain_fo_s  = new_frame ? gain_dn_s : gain_q;
    song_inc_s = (song_idx_q == LAST_SONG) ? {SONG_BITS{1'b0}} : (song_idx_q + SONG_BITS'(1));
    samp_ext_s = {{(PW-16){sample_in[15]}}, sample_in};
    gain_ext_s = {{(PW-GW){1'b0}}, gain_q};

    case (state_q)
      S_PAUSED: begin
        gain_d = {GW{1'b0}};
        if (next_pulse) begin
          song_idx_d       = song_inc_s;
          player_restart_d = 1'b1;
        end else if (play_pulse) begin
          state_d    = S_FADE_IN;
          play_led_d = 1'b1;
        end else begin
          state_d = S_PAUSED;
        end
      end
      S_FADE_IN, S_PLAYING: begin
        if (state_q == S_PLAYING) begin
          gain_d = GAIN_MAX;
        end else begin
          gain_d = new_frame ? gain_up_s : gain_q;
        end
        if (next_pulse) begin
          state_d  = S_FADE_OUT;
          target_d = T_NEXT;
        end else if (song_done) begin
          state_d = S_FADE_OUT;
`ifdef AUTO_ADVANCE_EN
          target_d = T_NEXT;
`else
          target_d   = T_REARM;
          play_led_d = 1'b0;
`endif
        end else if (play_pulse) begin
          state_d    = S_FADE_OUT;
          target_d   = T_PAUSE;
          play_led_d = 1'b0;
        end else if ((state_q == S_FADE_IN) && new_frame && (gain_up_s == GAIN_MAX)) begin
          state_d = S_PLAYING;
        end else begin
          state_d = state_q;
        end
      end
      S_FADE_OUT: begin
        gain_d = gain_fo_s;
        if (play_pulse && (target_q == T_NEXT)) begin
          target_d   = T_PAUSE;
          play_led_d = 1'b0;
        end else begin
          target_d = target_q;
        end
        // The song advances on entry to SWITCH so index and restart are visible while in it.
        if (gain_fo_s == {GW{1'b0}}) begin
          if (target_d == T_NEXT) begin
            state_d          = S_SWITCH;
            song_idx_d       = song_inc_s;
            player_restart_d = 1'b1;
          end else begin
            state_d          = S_PAUSED;
            player_restart_d = (target_d == T_REARM);
          end
        end else begin
          state_d = S_FADE_OUT;
        end
      end
      S_SWITCH: begin
        state_d = S_FADE_IN;
      end
      default: begin
        state_d = S_PAUSED;
        gain_d  = {GW{1'b0}};
      end
    endcase

    player_enable_d = (state_d != S_PAUSED);
    busy_d          = (state_d == S_FADE_IN) || (state_d == S_FADE_OUT) || (state_d == S_SWITCH);

    if (new_frame) begin
      sample_out_d = (state_q == S_PAUSED) ? 16'h0000
                                           : 16'((samp_ext_s * gain_ext_s) >>> GAIN_BITS);
    end else begin
      sample_out_d = sample_out_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_PAUSED;
      target_q         <= T_PAUSE;
      song_idx_q       <= {SONG_BITS{1'b0}};
      gain_q           <= {GW{1'b0}};
      sample_out_q     <= 16'h0000;
      player_enable_q  <= 1'b0;
      player_restart_q <= 1'b0;
      play_led_q       <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      song_idx_q       <= song_idx_d;
      gain_q           <= gain_d;
      sample_out_q     <= sample_out_d;
      player_enable_q  <= player_enable_d;
      player_restart_q <= player_restart_d;
      play_led_q       <= play_led_d;
      busy_q           <= busy_d;
    end
  end

  assign sample_out     = sample_out_q;
  assign player_enable  = player_enable_q;
  assign player_restart = player_restart_q;
  assign song_led       = song_idx_q;
  assign play_led       = play_led_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: transport model compared every cycle plus hand-computed pins.
module tb_playback_sequencer;
  localparam int NS   = 4;
  localparam int GB   = 5;
  localparam int GMAX = 32;
  localparam int D_PAUSE = 0;
  localparam int D_NEXT  = 1;
  localparam int D_REARM = 2;
`ifdef AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play_pulse = 1'b0, next_pulse = 1'b0, song_done = 1'b0, new_frame = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic [15:0] sample_out;
  logic        player_enable, player_restart, play_led, busy;
  logic [1:0]  song_led;

  int total = 0;
  int bad   = 0;

  // Model: running flag, ramp direction, pending switch, fade destination.
  bit          m_on, m_swap, m_led, m_restart;
  int          m_dir, m_dest, m_gain, m_song;
  logic [15:0] m_out;

  playback_sequencer dut (
    .clk(clk), .reset(reset), .play_pulse(play_pulse), .next_pulse(next_pulse),
    .song_done(song_done), .new_frame(new_frame), .sample_in(sample_in),
    .sample_out(sample_out), .player_enable(player_enable), .player_restart(player_restart),
    .song_led(song_led), .play_led(play_led), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> GB;
    return p[15:0];
  endfunction

  always @(posedge clk) begin : model
    bit n_on, n_swap, n_led, n_restart;
    int n_dir, n_dest, n_gain, n_song;
    logic [15:0] n_out;
    n_on = m_on; n_swap = m_swap; n_led = m_led; n_restart = 1'b0;
    n_dir = m_dir; n_dest = m_dest; n_gain = m_gain; n_song = m_song; n_out = m_out;
    if (reset) begin
      n_on = 0; n_swap = 0; n_led = 0; n_dir = 0; n_dest = D_PAUSE;
      n_gain = 0; n_song = 0; n_out = 16'h0000;
    end else begin
      if (new_frame) n_out = m_on ? scale(sample_in, m_gain) : 16'h0000;
      if (!m_on) begin
        if (next_pulse) begin
          n_song = (m_song + 1) % NS; n_restart = 1'b1;
        end else if (play_pulse) begin
          n_on = 1; n_dir = 1; n_led = 1;
        end
      end else if (m_swap) begin
        n_swap = 0; n_dir = 1;
      end else if (m_dir >= 0) begin
        if (new_frame && m_dir == 1) n_gain = (m_gain + 1 > GMAX) ? GMAX : m_gain + 1;
        if (next_pulse || (song_done && AUTO)) begin
          n_dir = -1; n_dest = D_NEXT;
        end else if (song_done) begin
          n_dir = -1; n_dest = D_REARM; n_led = 0;
        end else if (play_pulse) begin
          n_dir = -1; n_dest = D_PAUSE; n_led = 0;
        end else if (m_dir == 1 && n_gain == GMAX) begin
          n_dir = 0;
        end
      end else begin
        if (new_frame) n_gain = (m_gain > 0) ? m_gain - 1 : 0;
        if (play_pulse && m_dest == D_NEXT) begin
          n_dest = D_PAUSE; n_led = 0;
        end
        if (n_gain == 0) begin
          n_dir = 0;
          if (n_dest == D_NEXT) begin
            n_swap = 1; n_song = (m_song + 1) % NS; n_restart = 1'b1;
          end else begin
            n_on = 0; n_restart = (n_dest == D_REARM);
          end
        end
      end
    end
    m_on <= n_on; m_swap <= n_swap; m_led <= n_led; m_restart <= n_restart;
    m_dir <= n_dir; m_dest <= n_dest; m_gain <= n_gain; m_song <= n_song; m_out <= n_out;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sample_out", sample_out, m_out);
    chk("player_enable", 16'(player_enable), 16'(m_on));
    chk("player_restart", 16'(player_restart), 16'(m_restart));
    chk("song_led", 16'(song_led), 16'(m_song));
    chk("play_led", 16'(play_led), 16'(m_led));
    chk("busy", 16'(busy), 16'((m_dir != 0) || m_swap));
  endtask

  task automatic cyc(input bit pp, input bit np, input bit sd, input bit nf);
    play_pulse = pp; next_pulse = np; song_done = sd; new_frame = nf;
    @(negedge clk);
    compare_all();
    play_pulse = 1'b0; next_pulse = 1'b0; song_done = 1'b0; new_frame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lit_rst_sample", sample_out, 16'h0000);
    chk("lit_rst_enable", 16'(player_enable), 16'h0000);
    chk("lit_rst_busy", 16'(busy), 16'h0000);
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    // Fade-in at 0x4000.
    sample_in = 16'h4000;
    cyc(1, 0, 0, 0);
    chk("lit_play_enable", 16'(player_enable), 16'h0001);
    chk("lit_play_led", 16'(play_led), 16'h0001);
    chk("lit_play_busy", 16'(busy), 16'h0001);
    cyc(0, 0, 0, 1); chk("lit_ramp_f1", sample_out, 16'h0000); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("lit_ramp_f2", sample_out, 16'h0200); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("lit_ramp_f3", sample_out, 16'h0400); cyc(0, 0, 0, 0);
    frames(28);
    chk("lit_ramp_busy31", 16'(busy), 16'h0001);
    cyc(0, 0, 0, 1);
    chk("lit_ramp_f32", sample_out, 16'h3E00);
    chk("lit_playing_busy", 16'(busy), 16'h0000);
    cyc(0, 0, 0, 1);
    chk("lit_full_gain", sample_out, 16'h4000);
    cyc(0, 0, 0, 0);

    // Next song from PLAYING.
    cyc(0, 1, 0, 0);
    chk("lit_fo_busy", 16'(busy), 16'h0001);
    frames(31);
    cyc(0, 0, 0, 1);
    chk("lit_sw_restart", 16'(player_restart), 16'h0001);
    chk("lit_sw_song", 16'(song_led), 16'h0001);
    chk("lit_sw_led", 16'(play_led), 16'h0001);
    cyc(0, 0, 0, 0);
    chk("lit_sw_restart_end", 16'(player_restart), 16'h0000);
    frames(32);
    chk("lit_sw_playing", 16'(busy), 16'h0000);

    // Play+next together, then play during the fade-out.
    cyc(1, 1, 0, 0);
    chk("lit_pn_led", 16'(play_led), 16'h0001);
    frames(3);
    cyc(1, 0, 0, 0);
    chk("lit_pn_led_off", 16'(play_led), 16'h0000);
    frames(29);
    chk("lit_pn_enable", 16'(player_enable), 16'h0000);
    chk("lit_pn_song", 16'(song_led), 16'h0001);
    chk("lit_pn_busy", 16'(busy), 16'h0000);

    // Paused: song_done ignored, next wraps 3 -> 0.
    cyc(0, 0, 1, 0);
    chk("lit_sd_paused", 16'(player_enable), 16'h0000);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("lit_song3", 16'(song_led), 16'h0003);
    cyc(0, 1, 0, 0);
    chk("lit_wrap_song", 16'(song_led), 16'h0000);
    chk("lit_wrap_restart", 16'(player_restart), 16'h0001);
    chk("lit_wrap_enable", 16'(player_enable), 16'h0000);
    cyc(0, 0, 0, 0);
    chk("lit_wrap_restart_end", 16'(player_restart), 16'h0000);
    cyc(0, 0, 0, 1);
    chk("lit_paused_zero", sample_out, 16'h0000);

    // Negative full-scale at gain 16, then reset mid fade-out.
    sample_in = 16'h8000;
    cyc(1, 0, 0, 0);
    frames(16);
    cyc(0, 0, 0, 1);
    chk("lit_neg_g16", sample_out, 16'hC000);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    frames(3);
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("lit_mid_rst_sample", sample_out, 16'h0000);
    chk("lit_mid_rst_enable", 16'(player_enable), 16'h0000);
    chk("lit_mid_rst_led", 16'(play_led), 16'h0000);
    chk("lit_mid_rst_busy", 16'(busy), 16'h0000);
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    // End of song while playing.
    sample_in = 16'h1234;
    cyc(1, 0, 0, 0);
    frames(32);
    cyc(0, 0, 1, 0);
    frames(31);
    cyc(0, 0, 0, 1);
    chk("lit_sd_restart", 16'(player_restart), 16'h0001);
`ifdef AUTO_ADVANCE_EN
    chk("lit_sd_song", 16'(song_led), 16'h0001);
    chk("lit_sd_led", 16'(play_led), 16'h0001);
    chk("lit_sd_busy", 16'(busy), 16'h0001);
`else
    chk("lit_sd_song", 16'(song_led), 16'h0000);
    chk("lit_sd_led", 16'(play_led), 16'h0000);
    chk("lit_sd_enable", 16'(player_enable), 16'h0000);
`endif
    cyc(0, 0, 0, 0);
    chk("lit_sd_restart_end", 16'(player_restart), 16'h0000);
    frames(4);

    // Next request coinciding with a frame during fade-in.
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    reset = 1'b0;
    cyc(1, 0, 0, 0);
    frames(4);
    cyc(0, 1, 0, 1);
    chk("lit_nf_busy", 16'(busy), 16'h0001);
    frames(4);
    chk("lit_nf_still_fading", 16'(song_led), 16'h0000);
    frames(1);
    chk("lit_nf_song", 16'(song_led), 16'h0001);
    chk("lit_nf_busy_in", 16'(busy), 16'h0001);
    frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
